// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: latches a load/store from EX/MEM, runs the dmem req/ack handshake,
// stalls upstream until completion, resolves branches and raises a sticky fault on misalignment/timeout.
module mem_stage_ctrl #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_memread,
    input  logic              ex_memwrite,
    input  logic              ex_branch,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              flush,
    output logic              pc_src,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_rdata,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              wbv_q, wbv_d;
    logic              err_q, err_d;
    logic              mem_op;
    logic              in_idle;

    assign mem_op  = ex_valid & (ex_memread | ex_memwrite);
    assign in_idle = (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wbv_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    if (ex_addr[1:0] != 2'b00) begin
                        state_d = S_ERR;
                    end else begin
                        addr_d  = ex_addr;
                        wdata_d = ex_wdata;
                        we_d    = ex_memwrite & ~ex_memread;
                        state_d = S_REQ;
                    end
                end else if (ex_valid) begin
                    wbv_d = 1'b1;
                end
            end
            S_REQ: begin
                cnt_d = '0;
                if (dmem_ack) begin
                    rdata_d = dmem_rdata;
                    wbv_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // cnt_q counts WAIT cycles already spent, starting at 0 on the first one
                if (dmem_ack) begin
                    rdata_d = dmem_rdata;
                    wbv_d   = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
        req_d = (state_d == S_REQ) || (state_d == S_WAIT);
        err_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wbv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wbv_q   <= wbv_d;
            err_q   <= err_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wbv_q;
    assign wb_rdata   = rdata_q;
    assign err        = err_q;

    assign stall  = (in_idle & mem_op) | (state_q == S_REQ) | (state_q == S_WAIT) | (state_q == S_ERR);
    assign pc_src = in_idle & ex_valid & ex_branch & ex_zero & ~mem_op;
    assign flush  = pc_src;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: per-cycle vector table plus hand sequences for
// misalignment, timeout and mid-transaction reset.
module tb_mem_stage_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid, ex_memread, ex_memwrite, ex_branch, ex_zero;
    logic [DW-1:0] ex_addr, ex_wdata;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          stall, flush, pc_src, wb_valid, err;
    logic [DW-1:0] wb_rdata;

    int n_pass  = 0;
    int n_total = 0;

    mem_stage_ctrl #(.DATA_W(DW), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .flush(flush), .pc_src(pc_src),
        .wb_valid(wb_valid), .wb_rdata(wb_rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v, rd, wr, br, z;
        logic [DW-1:0] addr, wdata;
        logic          ack;
        logic [DW-1:0] rdata;
        logic          e_req, e_we, e_stall, e_flush, e_wbv, e_err;
        logic [DW-1:0] e_addr, e_wdata, e_rdata;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic v, rd, wr, br, z,
                                input logic [DW-1:0] addr, wdata,
                                input logic ack, input logic [DW-1:0] rdata,
                                input logic e_req, e_we, e_stall, e_flush, e_wbv, e_err,
                                input logic [DW-1:0] e_addr, e_wdata, e_rdata);
        vec_t t;
        t.v = v; t.rd = rd; t.wr = wr; t.br = br; t.z = z;
        t.addr = addr; t.wdata = wdata; t.ack = ack; t.rdata = rdata;
        t.e_req = e_req; t.e_we = e_we; t.e_stall = e_stall; t.e_flush = e_flush;
        t.e_wbv = e_wbv; t.e_err = e_err;
        t.e_addr = e_addr; t.e_wdata = e_wdata; t.e_rdata = e_rdata;
        return t;
    endfunction

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive(input logic v, rd, wr, br, z, input logic [DW-1:0] addr, wdata,
                         input logic ack, input logic [DW-1:0] rdata);
        ex_valid = v; ex_memread = rd; ex_memwrite = wr; ex_branch = br; ex_zero = z;
        ex_addr = addr; ex_wdata = wdata; dmem_ack = ack; dmem_rdata = rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int req_cycles;
        logic got_err;

        //        v rd wr br z  addr       wdata      ack rdata         req we st fl wbv er e_addr  e_wdata  e_rdata
        vecs[0]  = mk(1, 1, 0, 0, 0, 32'h10, 32'h0,    0, 32'h0,         0, 0, 1, 0, 0, 0, 32'h0,  32'h0,    32'h0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 32'h10, 32'h0,    1, 32'hDEADBEEF,  1, 0, 1, 0, 0, 0, 32'h10, 32'h0,    32'h0);
        vecs[2]  = mk(1, 1, 0, 0, 0, 32'h10, 32'h0,    0, 32'h0,         0, 0, 0, 0, 1, 0, 32'h0,  32'h0,    32'hDEADBEEF);
        vecs[3]  = mk(1, 0, 1, 0, 0, 32'h20, 32'h1234, 0, 32'h0,         0, 0, 1, 0, 0, 0, 32'h0,  32'h0,    32'hDEADBEEF);
        vecs[4]  = mk(1, 1, 0, 0, 0, 32'h44, 32'h9999, 0, 32'h0,         1, 1, 1, 0, 0, 0, 32'h20, 32'h1234, 32'hDEADBEEF);
        vecs[5]  = mk(1, 0, 0, 1, 1, 32'h48, 32'h7777, 0, 32'h0,         1, 1, 1, 0, 0, 0, 32'h20, 32'h1234, 32'hDEADBEEF);
        vecs[6]  = mk(1, 0, 1, 0, 0, 32'h4C, 32'h0,    0, 32'h0,         1, 1, 1, 0, 0, 0, 32'h20, 32'h1234, 32'hDEADBEEF);
        vecs[7]  = mk(1, 0, 1, 0, 0, 32'h20, 32'h1234, 1, 32'hDEADBEEF,  1, 1, 1, 0, 0, 0, 32'h20, 32'h1234, 32'hDEADBEEF);
        vecs[8]  = mk(1, 0, 1, 0, 0, 32'h20, 32'h1234, 0, 32'h0,         0, 0, 0, 0, 1, 0, 32'h0,  32'h0,    32'hDEADBEEF);
        vecs[9]  = mk(1, 0, 0, 1, 1, 32'h0,  32'h0,    0, 32'h0,         0, 0, 0, 1, 0, 0, 32'h0,  32'h0,    32'hDEADBEEF);
        vecs[10] = mk(1, 0, 0, 1, 0, 32'h0,  32'h0,    0, 32'h0,         0, 0, 0, 0, 1, 0, 32'h0,  32'h0,    32'hDEADBEEF);
        vecs[11] = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,    0, 32'h0,         0, 0, 0, 0, 1, 0, 32'h0,  32'h0,    32'hDEADBEEF);
        vecs[12] = mk(0, 0, 0, 1, 1, 32'h0,  32'h0,    0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0,  32'h0,    32'hDEADBEEF);
        vecs[13] = mk(1, 1, 0, 1, 1, 32'h30, 32'h0,    0, 32'h0,         0, 0, 1, 0, 0, 0, 32'h0,  32'h0,    32'hDEADBEEF);
        vecs[14] = mk(1, 1, 0, 1, 1, 32'h30, 32'h0,    1, 32'h0BADF00D,  1, 0, 1, 0, 0, 0, 32'h30, 32'h0,    32'hDEADBEEF);
        vecs[15] = mk(1, 1, 0, 1, 1, 32'h30, 32'h0,    0, 32'h0,         0, 0, 0, 0, 1, 0, 32'h0,  32'h0,    32'h0BADF00D);
        vecs[16] = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,    1, 32'h11111111,  0, 0, 0, 0, 0, 0, 32'h0,  32'h0,    32'h0BADF00D);
        vecs[17] = mk(0, 0, 0, 0, 0, 32'h0,  32'h0,    0, 32'h0,         0, 0, 0, 0, 0, 0, 32'h0,  32'h0,    32'h0BADF00D);

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check("rst_req", dmem_req, 0);
        check("rst_we", dmem_we, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_rdata", wb_rdata, 0);
        check("rst_err", err, 0);
        check("rst_stall", stall, 0);
        check("rst_flush", flush, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].rd, vecs[i].wr, vecs[i].br, vecs[i].z,
                  vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].rdata);
            #1;
            check($sformatf("v%0d_req", i), dmem_req, vecs[i].e_req);
            check($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
            check($sformatf("v%0d_flush", i), flush, vecs[i].e_flush);
            check($sformatf("v%0d_pcsrc", i), pc_src, vecs[i].e_flush);
            check($sformatf("v%0d_wbv", i), wb_valid, vecs[i].e_wbv);
            check($sformatf("v%0d_err", i), err, vecs[i].e_err);
            check($sformatf("v%0d_rdata", i), wb_rdata, vecs[i].e_rdata);
            if (vecs[i].e_req) begin
                check($sformatf("v%0d_we", i), dmem_we, vecs[i].e_we);
                check($sformatf("v%0d_addr", i), dmem_addr, vecs[i].e_addr);
                check($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
            end
        end

        // Misaligned load goes straight to a sticky fault without ever requesting
        do_reset();
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 32'h13, 0, 0, 0);
        #1;
        check("mis_stall0", stall, 1);
        check("mis_err0", err, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h5A5A5A5A);
            #1;
            check($sformatf("mis_err%0d", i + 1), err, 1);
            check($sformatf("mis_stall%0d", i + 1), stall, 1);
            check($sformatf("mis_req%0d", i + 1), dmem_req, 0);
        end

        // Timeout: no ack ever arrives
        do_reset();
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 32'h40, 0, 0, 0);
        req_cycles = 0;
        got_err = 1'b0;
        for (int i = 0; i < 20 && !got_err; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            if (err) got_err = 1'b1;
            else if (dmem_req) req_cycles++;
        end
        check("to_req_cycles", req_cycles, 5);
        check("to_err", err, 1);
        check("to_req_off", dmem_req, 0);
        check("to_stall", stall, 1);

        // Reset in the middle of WAIT, then a fresh load
        do_reset();
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 32'h50, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mr_req_wait", dmem_req, 1);
        #2;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("mr_req", dmem_req, 0);
        check("mr_err", err, 0);
        check("mr_wbv", wb_valid, 0);
        check("mr_stall", stall, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 32'h60, 0, 0, 0);
        #1;
        check("mr2_stall", stall, 1);
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 32'h60, 0, 1, 32'hA5A5A5A5);
        #1;
        check("mr2_req", dmem_req, 1);
        check("mr2_addr", dmem_addr, 32'h60);
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 32'h60, 0, 0, 0);
        #1;
        check("mr2_wbv", wb_valid, 1);
        check("mr2_rdata", wb_rdata, 32'hA5A5A5A5);
        check("mr2_stall_done", stall, 0);
        check("mr2_req_done", dmem_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
